// File: rtl/mem_if.sv
// mem_if: MAR/MDR request/response bus between the control unit and the memory responder
interface mem_if #(
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;
  modport master (output read, write, addr, wdata, input rdata, ready, busy, err);
  modport slave  (input read, write, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word RAM responder with four-phase handshake for the MAR/MDR bus
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic  clk,
  input logic  reset_n,
  mem_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wr;
  logic              r_both;
  logic              r_oor;
  logic              r_ready;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              w_req;
  logic              w_do_write;
  assign w_req      = bus.read | bus.write;
  assign w_do_write = r_state == S_ACCESS && r_wr && !r_both && !r_oor;
  assign bus.rdata  = r_rdata;
  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;
  // Handshake FSM: capture request, count wait states, complete access, hold until strobes drop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_both  <= 1'b0;
      r_oor   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_req) begin
            r_addr  <= bus.addr[ADDR_W-1:0];
            r_wdata <= bus.wdata;
            r_wr    <= bus.write;
            r_both  <= bus.read & bus.write;
            r_oor   <= |bus.addr[31:ADDR_W];
            r_cnt   <= 4'(WAIT_CYCLES);
            r_busy  <= 1'b1;
            r_state <= WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
          end
        S_WAIT:
          if (!w_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= S_ACCESS;
          end
        S_ACCESS: begin
          r_ready <= 1'b1;
          r_err   <= r_both | r_oor;
          if (!r_both && !r_wr) r_rdata <= r_oor ? '0 : r_mem[r_addr];
          r_state <= S_HOLD;
        end
        S_HOLD:
          if (!w_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
      endcase
    end
  // Backing store; never cleared, written only on a fault-free ACCESS edge
  always_ff @(posedge clk)
    if (w_do_write) r_mem[r_addr] <= r_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench against a word-array memory model
module tb_mem_responder;
  logic clk = 0;
  logic reset_n = 0;
  int pass = 0;
  int total = 0;
  int lat, pulses;
  logic e;
  logic [31:0] q;
  logic [31:0] exp_rdata = 0;
  logic [31:0] mdl [0:511];
  mem_if #(.DATA_W(32)) bus ();
  mem_if #(.DATA_W(32)) bus0 ();
  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  always #5 clk = ~clk;

  task automatic run_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.read = rd; bus.write = wr; bus.addr = a; bus.wdata = d;
    lat = -1; pulses = 0; e = 1'b0; q = '0;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; e = bus.err; q = bus.rdata; end
      if (n == 0) begin bus.addr = $urandom; bus.wdata = $urandom; end
    end
    repeat (3) begin @(posedge clk); #1; pulses += int'(bus.ready); end
    bus.read = 0; bus.write = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    bus.read = 0; bus.write = 0; bus.addr = 0; bus.wdata = 0;
    bus0.read = 0; bus0.write = 0; bus0.addr = 0; bus0.wdata = 0;
    reset_n = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (bus.ready !== 1'b0) $display("FAIL rst_ready got %b want 0", bus.ready); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else pass++;
    total++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else pass++;
    total++; if (bus.rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.rdata); else pass++;
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    run_req(0, 1, 32'h10, 32'hDEADBEEF); mdl[9'h10] = 32'hDEADBEEF;
    total++; if (lat !== 3) $display("FAIL wr_latency got %0d want 3", lat); else pass++;
    total++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else pass++;
    run_req(1, 0, 32'h10, 32'h0); exp_rdata = mdl[9'h10];
    total++; if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else pass++;
    total++; if (q !== exp_rdata) $display("FAIL rd_data got %h want %h", q, exp_rdata); else pass++;
  endtask

  task automatic test_both;
    run_req(1, 1, 32'h10, 32'h11111111);
    total++; if (e !== 1'b1) $display("FAIL both_err got %b want 1", e); else pass++;
    total++; if (q !== exp_rdata) $display("FAIL both_rdata got %h want %h", q, exp_rdata); else pass++;
    run_req(1, 0, 32'h10, 32'h0); exp_rdata = mdl[9'h10];
    total++; if (q !== exp_rdata) $display("FAIL both_ram got %h want %h", q, exp_rdata); else pass++;
  endtask

  task automatic test_oor;
    run_req(0, 1, 32'h0, 32'h12345678); mdl[0] = 32'h12345678;
    run_req(0, 1, 32'h200, 32'hCAFEF00D);
    total++; if (e !== 1'b1) $display("FAIL oor_wr_err got %b want 1", e); else pass++;
    total++; if (lat !== 3) $display("FAIL oor_latency got %0d want 3", lat); else pass++;
    run_req(1, 0, 32'h0, 32'h0); exp_rdata = mdl[0];
    total++; if (q !== exp_rdata) $display("FAIL oor_word0 got %h want %h", q, exp_rdata); else pass++;
    run_req(1, 0, 32'h8000_0010, 32'h0); exp_rdata = 0;
    total++; if (e !== 1'b1) $display("FAIL oor_rd_err got %b want 1", e); else pass++;
    total++; if (q !== 32'h0) $display("FAIL oor_rd_data got %h want 0", q); else pass++;
  endtask

  task automatic test_hold;
    run_req(0, 1, 32'h21, 32'h0BADF00D); mdl[9'h21] = 32'h0BADF00D;
    total++; if (pulses !== 0) $display("FAIL hold_extra_ready got %0d want 0", pulses); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL hold_busy_drop got %b want 0", bus.busy); else pass++;
    run_req(1, 0, 32'h21, 32'h0); exp_rdata = mdl[9'h21];
    total++; if (lat !== 3) $display("FAIL hold_next_latency got %0d want 3", lat); else pass++;
    total++; if (q !== exp_rdata) $display("FAIL hold_next_data got %h want %h", q, exp_rdata); else pass++;
  endtask

  task automatic test_withdraw;
    int seen = 0;
    run_req(0, 1, 32'h20, 32'h55AA55AA); mdl[9'h20] = 32'h55AA55AA;
    bus.write = 1; bus.addr = 32'h20; bus.wdata = 32'h99999999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b1) $display("FAIL wd_busy got %b want 1", bus.busy); else pass++;
    bus.write = 0;
    repeat (5) begin @(posedge clk); #1; seen += int'(bus.ready); end
    total++; if (seen !== 0) $display("FAIL wd_ready got %0d want 0", seen); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL wd_idle got %b want 0", bus.busy); else pass++;
    run_req(1, 0, 32'h20, 32'h0); exp_rdata = mdl[9'h20];
    total++; if (q !== exp_rdata) $display("FAIL wd_word got %h want %h", q, exp_rdata); else pass++;
  endtask

  task automatic test_reset_mid;
    run_req(0, 1, 32'h30, 32'hA5A50030); mdl[9'h30] = 32'hA5A50030;
    run_req(1, 0, 32'h30, 32'h0); exp_rdata = mdl[9'h30];
    bus.write = 1; bus.addr = 32'h30; bus.wdata = 32'hFFFF0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 0; #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got %b want 0", bus.busy); else pass++;
    total++; if (bus.rdata !== 32'h0) $display("FAIL rm_rdata got %h want 0", bus.rdata); else pass++;
    total++; if (bus.ready !== 1'b0 || bus.err !== 1'b0) $display("FAIL rm_pulses got %b%b want 00", bus.ready, bus.err); else pass++;
    bus.write = 0; exp_rdata = 0;
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    run_req(1, 0, 32'h30, 32'h0); exp_rdata = mdl[9'h30];
    total++; if (q !== exp_rdata) $display("FAIL rm_word got %h want %h", q, exp_rdata); else pass++;
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    logic rd, wr;
    int k;
    for (int i = 0; i < 8; i++) begin
      d = $urandom; run_req(0, 1, 32'h40 + i, d); mdl[9'h40 + i] = d;
    end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      a = 32'h40 + $urandom_range(0, 7); d = $urandom;
      rd = k == 0 || k >= 6; wr = (k >= 2 && k <= 5) || k == 0;
      if (k == 1) begin a = a | (32'h1 << $urandom_range(9, 31)); rd = $urandom_range(0, 1) == 1; wr = !rd; end
      run_req(rd, wr, a, d);
      if (k == 1 && rd) exp_rdata = 0;
      else if (k >= 6) exp_rdata = mdl[a[8:0]];
      else if (k >= 2) mdl[a[8:0]] = d;
      total++; if (lat !== 3) $display("FAIL rnd_latency op %0d got %0d want 3", i, lat); else pass++;
      total++; if (e !== (k <= 1)) $display("FAIL rnd_err op %0d got %b want %b", i, e, k <= 1); else pass++;
      total++; if (q !== exp_rdata) $display("FAIL rnd_rdata op %0d got %h want %h", i, q, exp_rdata); else pass++;
    end
  endtask

  task automatic test_zero_wait;
    bus0.write = 1; bus0.addr = 32'h5; bus0.wdata = 32'h76543210;
    @(posedge clk); #1;
    total++; if (bus0.ready !== 1'b0) $display("FAIL zw_early got %b want 0", bus0.ready); else pass++;
    @(posedge clk); #1;
    total++; if (bus0.ready !== 1'b1) $display("FAIL zw_wr_ready got %b want 1", bus0.ready); else pass++;
    bus0.write = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus0.read = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus0.ready !== 1'b1) $display("FAIL zw_rd_ready got %b want 1", bus0.ready); else pass++;
    total++; if (bus0.rdata !== 32'h76543210) $display("FAIL zw_rd_data got %h want 76543210", bus0.rdata); else pass++;
    bus0.read = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_both;
    test_oor;
    test_hold;
    test_withdraw;
    test_reset_mid;
    test_zero_wait;
    test_random;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
